// File: rtl/dram_slot_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dram_slot_scheduler : video/CPU/refresh DRAM slot arbiter, registered strobes
// Optional refresh engine enabled by macro DRAM_REFRESH_EN.  Rev 1.0
// ============================================================================
module dram_slot_scheduler #(
    parameter int REFRESH_INTERVAL = 128
) (
    input  logic        CLK10,
    input  logic        RESETn,
    input  logic        VIDREQ,
    input  logic [15:0] VIDADDR,
    input  logic        CPUREQ,
    input  logic        CPUWE,
    input  logic [15:0] CPUADDR,
    output logic        VIDACK,
    output logic        CPUACK,
    output logic        RASn,
    output logic        CASn,
    output logic        WEn,
    output logic        MUXSEL,
    output logic [7:0]  DRADDR,
    output logic        REFRESH
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ROW   = 3'd1,
        COL   = 3'd2,
        PRE   = 3'd3,
        RROW  = 3'd4,
        RHOLD = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OWN_VID = 2'd0,
        OWN_CPU = 2'd1,
        OWN_REF = 2'd2
    } owner_t;

    state_t      state, state_nx;
    owner_t      owner, owner_nx;
    logic [15:0] addr, addr_nx;
    logic        wr, wr_nx;
    logic [1:0]  starve_cnt, starve_nx;
    logic        refresh_req;
    logic [6:0]  row_cnt;
    logic        cpu_starved, grant_ref, grant_cpu, grant_vid;
    logic        ras_nx, cas_nx, we_nx, mux_nx, vack_nx, cack_nx, rfsh_nx;
    logic [7:0]  dra_nx;

    assign cpu_starved = (starve_cnt == 2'd2);
    assign grant_ref   = (state == IDLE) && refresh_req;
    assign grant_cpu   = (state == IDLE) && !refresh_req && CPUREQ && (cpu_starved || !VIDREQ);
    assign grant_vid   = (state == IDLE) && !refresh_req && VIDREQ && !(CPUREQ && cpu_starved);

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        addr_nx   = addr;
        wr_nx     = wr;
        starve_nx = starve_cnt;
        case (state)
            IDLE: begin
                if (grant_ref) begin
                    state_nx = RROW;
                    owner_nx = OWN_REF;
                    wr_nx    = 1'b0;
                end else if (grant_cpu) begin
                    state_nx  = ROW;
                    owner_nx  = OWN_CPU;
                    addr_nx   = CPUADDR;
                    wr_nx     = CPUWE;
                    starve_nx = 2'd0;
                end else if (grant_vid) begin
                    state_nx  = ROW;
                    owner_nx  = OWN_VID;
                    addr_nx   = VIDADDR;
                    wr_nx     = 1'b0;
                    // Saturating count of video wins taken while the CPU waited
                    starve_nx = CPUREQ ? (cpu_starved ? 2'd2 : starve_cnt + 2'd1) : 2'd0;
                end
            end
            ROW:     state_nx = COL;
            COL:     state_nx = PRE;
            RROW:    state_nx = RHOLD;
            RHOLD:   state_nx = PRE;
            PRE:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output values for the state being entered, so every pin comes off a flop
    always_comb begin
        ras_nx  = 1'b1;
        cas_nx  = 1'b1;
        we_nx   = 1'b1;
        mux_nx  = 1'b0;
        vack_nx = 1'b0;
        cack_nx = 1'b0;
        rfsh_nx = 1'b0;
        dra_nx  = 8'h00;
        case (state_nx)
            ROW: begin
                ras_nx = 1'b0;
                dra_nx = addr_nx[7:0];
            end
            COL: begin
                ras_nx = 1'b0;
                cas_nx = 1'b0;
                mux_nx = 1'b1;
                we_nx  = !((owner_nx == OWN_CPU) && wr_nx);
                dra_nx = addr_nx[15:8];
            end
            RROW, RHOLD: begin
                ras_nx  = 1'b0;
                rfsh_nx = 1'b1;
                dra_nx  = {1'b0, row_cnt};
            end
            PRE: begin
                rfsh_nx = (owner_nx == OWN_REF);
                vack_nx = (owner_nx == OWN_VID);
                cack_nx = (owner_nx == OWN_CPU);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK10 or negedge RESETn) begin
        if (!RESETn) begin
            state      <= IDLE;
            owner      <= OWN_VID;
            addr       <= 16'h0000;
            wr         <= 1'b0;
            starve_cnt <= 2'd0;
            RASn       <= 1'b1;
            CASn       <= 1'b1;
            WEn        <= 1'b1;
            MUXSEL     <= 1'b0;
            DRADDR     <= 8'h00;
            VIDACK     <= 1'b0;
            CPUACK     <= 1'b0;
            REFRESH    <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            addr       <= addr_nx;
            wr         <= wr_nx;
            starve_cnt <= starve_nx;
            RASn       <= ras_nx;
            CASn       <= cas_nx;
            WEn        <= we_nx;
            MUXSEL     <= mux_nx;
            DRADDR     <= dra_nx;
            VIDACK     <= vack_nx;
            CPUACK     <= cack_nx;
            REFRESH    <= rfsh_nx;
        end
    end

`ifdef DRAM_REFRESH_EN
    logic [9:0] interval_cnt;
    logic       pending;
    logic       tick;

    assign tick        = (interval_cnt == 10'(REFRESH_INTERVAL - 1));
    assign refresh_req = pending | tick;

    always_ff @(posedge CLK10 or negedge RESETn) begin
        if (!RESETn) begin
            interval_cnt <= 10'd0;
            pending      <= 1'b0;
            row_cnt      <= 7'd0;
        end else begin
            interval_cnt <= tick ? 10'd0 : interval_cnt + 10'd1;
            // A tick landing on a grant that pending already owned must not be lost
            pending      <= grant_ref ? (pending & tick) : (pending | tick);
            if ((state == PRE) && (owner == OWN_REF))
                row_cnt <= row_cnt + 7'd1;
        end
    end
`else
    localparam int unused_refresh_interval = REFRESH_INTERVAL;
    assign refresh_req = 1'b0;
    assign row_cnt     = 7'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_slot_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dram_slot_scheduler : directed vector bench for dram_slot_scheduler. Rev 1.0
// ============================================================================
module tb_dram_slot_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vreq, creq, cwe;
    logic [15:0] vaddr, caddr;
    logic        VIDACK, CPUACK, RASn, CASn, WEn, MUXSEL, REFRESH;
    logic [7:0]  DRADDR;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_slot_scheduler #(.REFRESH_INTERVAL(1023)) dut (
        .CLK10(clk), .RESETn(rst_n),
        .VIDREQ(vreq), .VIDADDR(vaddr),
        .CPUREQ(creq), .CPUWE(cwe), .CPUADDR(caddr),
        .VIDACK(VIDACK), .CPUACK(CPUACK),
        .RASn(RASn), .CASn(CASn), .WEn(WEn),
        .MUXSEL(MUXSEL), .DRADDR(DRADDR), .REFRESH(REFRESH)
    );

`ifdef DRAM_REFRESH_EN
    logic        vreq_r;
    logic [15:0] vaddr_r;
    logic        VIDACK_r, CPUACK_r, RASn_r, CASn_r, WEn_r, MUXSEL_r, REFRESH_r;
    logic [7:0]  DRADDR_r;

    dram_slot_scheduler #(.REFRESH_INTERVAL(16)) dut_r (
        .CLK10(clk), .RESETn(rst_n),
        .VIDREQ(vreq_r), .VIDADDR(vaddr_r),
        .CPUREQ(1'b0), .CPUWE(1'b0), .CPUADDR(16'h0000),
        .VIDACK(VIDACK_r), .CPUACK(CPUACK_r),
        .RASn(RASn_r), .CASn(CASn_r), .WEn(WEn_r),
        .MUXSEL(MUXSEL_r), .DRADDR(DRADDR_r), .REFRESH(REFRESH_r)
    );

    function automatic logic [14:0] obs_r(input logic keep_dr);
        return {2'b00, RASn_r, CASn_r, REFRESH_r, VIDACK_r, CPUACK_r,
                keep_dr ? DRADDR_r : 8'h00};
    endfunction
`endif

    typedef struct {
        logic        vid;
        logic [15:0] va;
        logic        cpu;
        logic        we;
        logic [15:0] ca;
        logic        exp_cpu;
        logic [15:0] exp_addr;
        logic        exp_wen;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [14:0] mk(input logic ras, input logic cas, input logic we,
                                       input logic mux, input logic va, input logic ca,
                                       input logic rf, input logic [7:0] dr);
        return {ras, cas, we, mux, va, ca, rf, dr};
    endfunction

    function automatic logic [14:0] obs(input logic keep_dr);
        return {RASn, CASn, WEn, MUXSEL, VIDACK, CPUACK, REFRESH, keep_dr ? DRADDR : 8'h00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vreq  = 1'b0;
        creq  = 1'b0;
        cwe   = 1'b0;
`ifdef DRAM_REFRESH_EN
        vreq_r = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] seq_exp [6];
        logic       seen;
        int         n;

        vecs[0] = '{1'b1, 16'hAB12, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hAB12, 1'b1};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h3456, 1'b1, 16'h3456, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h00FF, 1'b1, 16'h00FF, 1'b1};
        vecs[3] = '{1'b1, 16'h1111, 1'b1, 1'b1, 16'h2222, 1'b0, 16'h1111, 1'b1};
        vecs[4] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1};
        seq_exp = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};

        rst_n = 1'b0;
        vreq = 1'b0; creq = 1'b0; cwe = 1'b0;
        vaddr = 16'h0000; caddr = 16'h0000;
`ifdef DRAM_REFRESH_EN
        vreq_r = 1'b0; vaddr_r = 16'h0000;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", obs(1'b1), mk(1, 1, 1, 0, 0, 0, 0, 8'h00));
        rst_n = 1'b1;

        // Single transactions from IDLE, inputs scrambled after grant
        for (int i = 0; i < 5; i++) begin
            vreq = vecs[i].vid; vaddr = vecs[i].va;
            creq = vecs[i].cpu; cwe = vecs[i].we; caddr = vecs[i].ca;
            step();
            check($sformatf("v%0d row", i), obs(1'b1), mk(0, 1, 1, 0, 0, 0, 0, vecs[i].exp_addr[7:0]));
            vaddr = ~vecs[i].va; caddr = ~vecs[i].ca; cwe = ~vecs[i].we;
            step();
            check($sformatf("v%0d col", i), obs(1'b1),
                  mk(0, 0, vecs[i].exp_wen, 1, 0, 0, 0, vecs[i].exp_addr[15:8]));
            step();
            check($sformatf("v%0d pre", i), obs(1'b0),
                  mk(1, 1, 1, 0, !vecs[i].exp_cpu, vecs[i].exp_cpu, 0, 8'h00));
            vreq = 1'b0; creq = 1'b0;
            step();
            check($sformatf("v%0d idle", i), obs(1'b0), mk(1, 1, 1, 0, 0, 0, 0, 8'h00));
        end

        // Both requesters held high: V,V,C repeating
        do_reset();
        vreq = 1'b1; vaddr = 16'h5555;
        creq = 1'b1; caddr = 16'h6666; cwe = 1'b0;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!(VIDACK || CPUACK) && n < 8);
            check($sformatf("starve grant %0d", g), {13'd0, VIDACK, CPUACK}, {13'd0, seq_exp[g]});
        end
        vreq = 1'b0; creq = 1'b0;
        step();

        // Reset dropped mid-access during COL of a CPU write
        do_reset();
        creq = 1'b1; cwe = 1'b1; caddr = 16'h789A;
        step();
        step();
        check("abort col", obs(1'b1), mk(0, 0, 0, 1, 0, 0, 0, 8'h78));
        #2;
        rst_n = 1'b0;
        creq = 1'b0;
        #1;
        check("abort strobes", obs(1'b1), mk(1, 1, 1, 0, 0, 0, 0, 8'h00));
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            step();
            if (CPUACK || VIDACK) seen = 1'b1;
        end
        check("abort no ack", {14'd0, seen}, 15'd0);
        creq = 1'b1; cwe = 1'b0; caddr = 16'hBCDE;
        step();
        check("post reset row", obs(1'b1), mk(0, 1, 1, 0, 0, 0, 0, 8'hDE));
        step();
        step();
        check("post reset pre", obs(1'b0), mk(1, 1, 1, 0, 0, 1, 0, 8'h00));
        creq = 1'b0;
        step();

`ifdef DRAM_REFRESH_EN
        begin
            int         last;
            logic [6:0] rw;
            do_reset();
            last = 0;
            for (int k = 0; k < 131; k++) begin
                n = 0;
                while (!REFRESH_r && n < 40) begin
                    step();
                    n++;
                end
                if (k > 0) check_int($sformatf("ref%0d period", k), cyc - last, 16);
                last = cyc;
                rw = 7'(k % 128);
                check($sformatf("ref%0d rrow", k), obs_r(1'b1), {2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rw});
                step();
                check($sformatf("ref%0d rhold", k), obs_r(1'b1), {2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rw});
                step();
                check($sformatf("ref%0d pre", k), obs_r(1'b0), {2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
            end
            while (cyc < last + 15) step();
            vreq_r = 1'b1; vaddr_r = 16'hC3D4;
            step();
            check("tick vs video", obs_r(1'b1), {2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h03});
            n = 0;
            while (!VIDACK_r && n < 12) begin
                step();
                n++;
            end
            check_int("video after refresh", cyc - last, 22);
            vreq_r = 1'b0;
            step();
        end
`else
        do_reset();
        seen = 1'b0;
        repeat (300) begin
            step();
            if (REFRESH || !RASn) seen = 1'b1;
        end
        check("no refresh when disabled", {14'd0, seen}, 15'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
